catch_round_controller: RTL
===========================

// Module: catch_round_controller
// PURPOSE
//  Game sequencer for the LED catcher. It paces the LED bouncer with a one-cycle step pulse
//  and detects catches (switch rising edge on the lit LED). It owns the 3 s post-catch freeze,
//  score, difficulty level and a fixed-length round timer. Sits between the switch inputs,
//  the one-hot LED bouncer datapath and the Bin2BCD/display path.
// PARAMETERS
//  BASE_PERIOD        4    ticks between steps at level 0
//  MIN_PERIOD         1    floor on step period
//  FREEZE_TICKS       30   freeze length after a catch (30 ticks = 3 s at 10 Hz)
//  GAME_TICKS         600  round length in ticks (60 s)
//  CATCHES_PER_LEVEL  5    catches needed per level increment
//  MAX_LEVEL          3    level saturation value
//  SCORE_MAX          999  score saturation value (fits 3 BCD digits)
// PORTS
//  clk_10Hz     in   1   game tick clock
//  rst          in   1   reset, asynchronous, active-high
//  start        in   1   level input; rising edge starts/restarts a round
//  switch       in   16  player switches, already synchronous to clk_10Hz
//  led_onehot   in   16  current bouncer LED (one-hot; all-zero tolerated = nothing lit)
//  step         out  1   one-cycle advance pulse to bouncer
//  frozen       out  1   high while in FREEZE
//  catch_pulse  out  1   one cycle, on a counted catch
//  miss_pulse   out  1   one cycle, switch edge with no lit match
//  score        out  10  catches this round, saturating at SCORE_MAX
//  level        out  2   difficulty level 0..MAX_LEVEL
//  time_left    out  10  remaining round ticks
//  game_over    out  1   high in OVER
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; prev_switch=0, prev_start=0, div_cnt=0, freeze_cnt=0.
//  - edges = switch & ~prev_switch; hit = |(edges & led_onehot); prev_switch updates every cycle, all states.
//  - period = max(BASE_PERIOD - level, MIN_PERIOD).
//  - IDLE: step=0. On start rising edge -> PLAY; load time_left=GAME_TICKS; clear score, level, div_cnt.
//  - PLAY: div_cnt increments; when div_cnt==period-1, step=1 that cycle and div_cnt wraps to 0.
//    hit -> catch_pulse=1, score+1 (sat), hit counter+1; on reaching CATCHES_PER_LEVEL, counter clears
//    and level+1 (sat at MAX_LEVEL). Then state -> FREEZE, freeze_cnt=FREEZE_TICKS-1, div_cnt=0, step forced 0.
//    edges!=0 and no hit -> miss_pulse=1; score unchanged.
//    Multiple edges in one cycle: at most one catch counted. hit takes precedence over miss.
//  - FREEZE: step=0, frozen=1; edges ignored (no pulses). freeze_cnt decrements; at 0 -> PLAY next cycle.
//    Total freeze is exactly FREEZE_TICKS cycles.
//  - time_left decrements by 1 each cycle in PLAY and FREEZE. The cycle it goes 1->0: state -> OVER.
//    OVER outranks FREEZE entry; a catch in that same cycle is still scored.
//  - OVER: game_over=1, step=0; score/level held. start rising edge -> PLAY with full reload (as from IDLE).
//  - start rising edge in PLAY/FREEZE: ignored.
//  - rst mid-round: immediate return to reset values; no pulse emitted.
//  - Outputs are registered; step/catch/miss go high the cycle after the causing condition.
// STRUCTURE
//  - Package catch_game_pkg: state encoding {IDLE, PLAY, FREEZE, OVER}; width constants (SCORE_W=10,
//    TIME_W=10, LVL_W=2, LED_N=16); default parameter values.
//  - Sub-module switch_edge_detect (LED_N-wide prev register + rising-edge mask). Shared with other
//    switch consumers. FSM, divider, counters stay in this module.
// TESTING
//  1 rst held, then released, start idle -> all outputs 0, state IDLE for 20 cycles.
//  2 start edge, led_onehot fixed, no switches -> step every 4 cycles; time_left 600->0 over 600 cycles;
//    game_over=1 after that, score 0.
//  3 led_onehot=16'h0100, switch[8] 0->1 in PLAY -> catch_pulse 1 cycle, score=1, frozen=1 for exactly
//    30 cycles, no step in freeze, step resumes 4 cycles after.
//  4 Five catches -> level=1, step period 3; nineteen more catches -> level saturates at 3, period 1.
//  5 switch[3] edge while led_onehot=16'h0100 -> miss_pulse, score unchanged. Edges on [3] and [8]
//    together -> single catch, no miss.
//  6 Catch on the cycle time_left hits 0 -> score incremented, state OVER (not FREEZE). Assert rst
//    during FREEZE -> outputs 0, IDLE.

Source files
------------

// File: rtl/catch_game_pkg.sv
// Shared types and sizing for the LED catcher game: state encoding,
// bus widths and default tuning values for the round controller.
package catch_game_pkg;

  localparam int SCORE_W = 10;
  localparam int TIME_W  = 10;
  localparam int LVL_W   = 2;
  localparam int LED_N   = 16;

  localparam int BASE_PERIOD_DEF       = 4;
  localparam int MIN_PERIOD_DEF        = 1;
  localparam int FREEZE_TICKS_DEF      = 30;
  localparam int GAME_TICKS_DEF        = 600;
  localparam int CATCHES_PER_LEVEL_DEF = 5;
  localparam int MAX_LEVEL_DEF         = 3;
  localparam int SCORE_MAX_DEF         = 999;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FREEZE = 2'd2,
    ST_OVER   = 2'd3
  } game_state_e;

endpackage

// File: rtl/switch_edge_detect.sv
// Rising-edge mask for already-synchronous switch inputs; previous-value
// register updates every cycle so the mask is valid in any consumer state.
module switch_edge_detect #(
  parameter int N = 16
) (
  input  logic         clk_10Hz,
  input  logic         rst,
  input  logic [N-1:0] sw_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] prev_q;

  always_ff @(posedge clk_10Hz or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= sw_i;
  end

  assign rise_o = sw_i & ~prev_q;

endmodule

// File: rtl/catch_round_controller.sv
// Round sequencer for the LED catcher: paces the bouncer, scores catches,
// applies the post-catch freeze, tracks difficulty level and the round timer.
module catch_round_controller
  import catch_game_pkg::*;
#(
  parameter int BASE_PERIOD       = BASE_PERIOD_DEF,
  parameter int MIN_PERIOD        = MIN_PERIOD_DEF,
  parameter int FREEZE_TICKS      = FREEZE_TICKS_DEF,
  parameter int GAME_TICKS        = GAME_TICKS_DEF,
  parameter int CATCHES_PER_LEVEL = CATCHES_PER_LEVEL_DEF,
  parameter int MAX_LEVEL         = MAX_LEVEL_DEF,
  parameter int SCORE_MAX         = SCORE_MAX_DEF
) (
  input  logic               clk_10Hz,
  input  logic               rst,
  input  logic               start,
  input  logic [LED_N-1:0]   switch,
  input  logic [LED_N-1:0]   led_onehot,
  output logic               step,
  output logic               frozen,
  output logic               catch_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [LVL_W-1:0]   level,
  output logic [TIME_W-1:0]  time_left,
  output logic               game_over
);

  localparam int DIV_W = $clog2(BASE_PERIOD + 1);
  localparam int FRZ_W = $clog2(FREEZE_TICKS + 1);
  localparam int HIT_W = $clog2(CATCHES_PER_LEVEL + 1);

  game_state_e        state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [FRZ_W-1:0]   freeze_q, freeze_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic               step_q, step_d;
  logic               catch_q, catch_d;
  logic               miss_q, miss_d;
  logic               start_q;

  logic [LED_N-1:0]   edges;
  logic               hit;
  logic               start_rise;
  int                 period_i;
  logic [DIV_W-1:0]   period_m1;

  switch_edge_detect #(.N(LED_N)) u_edge (
    .clk_10Hz (clk_10Hz),
    .rst      (rst),
    .sw_i     (switch),
    .rise_o   (edges)
  );

  assign hit        = |(edges & led_onehot);
  assign start_rise = start & ~start_q;

  // Step period shrinks one tick per level, floored at MIN_PERIOD.
  always_comb begin
    period_i = BASE_PERIOD - int'(level_q);
    if (period_i < MIN_PERIOD) period_i = MIN_PERIOD;
    period_m1 = DIV_W'(period_i - 1);
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    freeze_d = freeze_q;
    time_d   = time_q;
    score_d  = score_q;
    level_d  = level_q;
    hits_d   = hits_q;
    step_d   = 1'b0;
    catch_d  = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d = ST_PLAY;
          time_d  = TIME_W'(GAME_TICKS);
          score_d = '0;
          level_d = '0;
          hits_d  = '0;
          div_d   = '0;
        end
      end
      ST_PLAY: begin
        time_d = time_q - TIME_W'(1);
        if (hit) begin
          catch_d = 1'b1;
          if (score_q != SCORE_W'(SCORE_MAX)) score_d = score_q + SCORE_W'(1);
          if (hits_q == HIT_W'(CATCHES_PER_LEVEL - 1)) begin
            hits_d = '0;
            if (level_q != LVL_W'(MAX_LEVEL)) level_d = level_q + LVL_W'(1);
          end else begin
            hits_d = hits_q + HIT_W'(1);
          end
          div_d    = '0;
          freeze_d = FRZ_W'(FREEZE_TICKS - 1);
          state_d  = ST_FREEZE;
        end else begin
          miss_d = |edges;
          if (div_q == period_m1) begin
            div_d  = '0;
            step_d = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        // Round expiry wins over freeze entry and swallows a pending step.
        if (time_q == TIME_W'(1)) begin
          state_d = ST_OVER;
          step_d  = 1'b0;
        end
      end
      ST_FREEZE: begin
        time_d = time_q - TIME_W'(1);
        if (time_q == TIME_W'(1))  state_d  = ST_OVER;
        else if (freeze_q == '0)   state_d  = ST_PLAY;
        else                       freeze_d = freeze_q - FRZ_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_10Hz or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      freeze_q <= '0;
      time_q   <= '0;
      score_q  <= '0;
      level_q  <= '0;
      hits_q   <= '0;
      step_q   <= 1'b0;
      catch_q  <= 1'b0;
      miss_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      freeze_q <= freeze_d;
      time_q   <= time_d;
      score_q  <= score_d;
      level_q  <= level_d;
      hits_q   <= hits_d;
      step_q   <= step_d;
      catch_q  <= catch_d;
      miss_q   <= miss_d;
      start_q  <= start;
    end
  end

  assign step        = step_q;
  assign catch_pulse = catch_q;
  assign miss_pulse  = miss_q;
  assign score       = score_q;
  assign level       = level_q;
  assign time_left   = time_q;
  assign frozen      = (state_q == ST_FREEZE);
  assign game_over   = (state_q == ST_OVER);

endmodule
